module_synchro_counter_n: RTL

Parametrised successor to the 8-bit synchro counter. It counts edges of an asynchronous, slow event input `clk_in` in the `qzt_clk` domain, modulo a run-time `limit`, and can count up or down. It has synchronous clear and parallel load, a configurable synchroniser depth and edge polarity, a one-cycle wrap pulse and a held wrap flag. Instances are chained into the DCF77 time-of-day chain (seconds → minutes → hours → day) and are also used as free dividers.

---
 rtl/module_synchro_counter_n.sv | 115 +++++++++++
 1 files changed

// File: rtl/module_synchro_counter_n.sv
// Purpose: counts edges of a slow asynchronous event input modulo a run-time limit, up or down, with clear/load.
// Latency: a counted clk_in edge first captured at qzt_clk edge N updates out/carry/carry_hold at edge N+SYNC_STAGES.
// Backpressure: none; clk_in phases shorter than 2 qzt_clk periods may lose events, clear/load override an event.
module module_synchro_counter_n #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE        = 0
) (
    input  logic             qzt_clk,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up_down,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             carry_hold
);

    // Level clk_in sits at after a counted edge. Resetting the synchroniser to
    // this level means an input already parked there at reset release is not
    // mistaken for a fresh edge.
    localparam logic IDLE_LVL = (EDGE == 0) ? 1'b1 : 1'b0;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_last;
    logic                   evt;

    // Largest legal count, M-1. limit = 0 wraps to all ones, i.e. M = 2^WIDTH.
    logic [WIDTH-1:0] top;

    logic [WIDTH-1:0] nxt_out;
    logic             nxt_carry;
    logic             nxt_hold;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign top       = limit - ONE;

    // Synchroniser chain followed by a previous-value flop for edge detection.
    always_ff @(posedge qzt_clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{IDLE_LVL}};
            prev_q <= IDLE_LVL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
            prev_q <= sync_last;
        end
    end

    // One-cycle event on the selected transition of the synchronised input.
    always_comb begin
        if (EDGE == 0) begin
            evt = sync_last & ~prev_q;
        end else begin
            evt = ~sync_last & prev_q;
        end
    end

    // Next count and flags: clear beats load beats event; losers are dropped.
    always_comb begin
        nxt_out   = out;
        nxt_carry = 1'b0;
        nxt_hold  = carry_hold;
        if (clear) begin
            nxt_out  = '0;
            nxt_hold = 1'b0;
        end else if (load) begin
            nxt_out  = load_value;
            nxt_hold = 1'b0;
        end else if (evt) begin
            if (up_down) begin
                // Anything at or beyond the top (e.g. after limit shrank) wraps to 0.
                if (out >= top) begin
                    nxt_out   = '0;
                    nxt_carry = 1'b1;
                    nxt_hold  = 1'b1;
                end else begin
                    nxt_out  = out + ONE;
                    nxt_hold = 1'b0;
                end
            end else begin
                if (out == '0) begin
                    nxt_out   = top;
                    nxt_carry = 1'b1;
                    nxt_hold  = 1'b1;
                end else if (out > top) begin
                    // Out-of-range value is pulled back into range without a wrap.
                    nxt_out  = top;
                    nxt_hold = 1'b0;
                end else begin
                    nxt_out  = out - ONE;
                    nxt_hold = 1'b0;
                end
            end
        end
    end

    // Registered count and wrap flags.
    always_ff @(posedge qzt_clk or negedge reset) begin
        if (!reset) begin
            out        <= '0;
            carry      <= 1'b0;
            carry_hold <= 1'b0;
        end else begin
            out        <= nxt_out;
            carry      <= nxt_carry;
            carry_hold <= nxt_hold;
        end
    end

endmodule
